// File: rtl/izigzag_buffer.sv
// Inverse-zigzag reorder buffer: takes 8x8 coefficient blocks in JPEG zigzag order and emits
// them in raster order through two ping-pong banks. Optional flush input: define IZZ_FLUSH_EN.
module izigzag_buffer #(
  parameter int COEFF_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
`ifdef IZZ_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               din_valid,
  input  logic [COEFF_W-1:0] din,
  output logic               din_ready,
  output logic               dout_valid,
  output logic [COEFF_W-1:0] dout,
  output logic [5:0]         dout_idx,
  output logic               dout_last,
  input  logic               dout_ready
);

  // Zigzag position -> raster index.
  localparam logic [5:0] ZZ [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [COEFF_W-1:0] mem [0:127];
  logic [5:0]         wr_cnt;
  logic [5:0]         rd_cnt;
  logic               wr_bank;
  logic               rd_bank;
  logic [1:0]         full;
  logic               flush_req;
  logic               accept;
  logic               fetch;
  logic               wr_done;
  logic               rd_done;

`ifdef IZZ_FLUSH_EN
  assign flush_req = ena & flush;
`else
  assign flush_req = 1'b0;
`endif

  assign din_ready = ena & ~rst & ~full[wr_bank] & ~flush_req;
  assign accept    = din_valid & din_ready;
  assign fetch     = ena & full[rd_bank] & (~dout_valid | dout_ready);
  assign wr_done   = accept & (wr_cnt == 6'd63);
  assign rd_done   = fetch & (rd_cnt == 6'd63);

  // Storage has no reset so it maps onto block RAM; the full[] flags guard against stale reads.
  always_ff @(posedge clk) begin
    if (accept)
      mem[{wr_bank, ZZ[wr_cnt]}] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= 6'd0;
      wr_bank <= 1'b0;
    end else if (flush_req) begin
      wr_cnt  <= 6'd0;
    end else if (accept) begin
      wr_cnt <= wr_cnt + 6'd1;
      if (wr_done)
        wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= 6'd0;
      rd_bank <= 1'b0;
    end else if (fetch) begin
      rd_cnt <= rd_cnt + 6'd1;
      if (rd_done)
        rd_bank <= ~rd_bank;
    end
  end

  // Writer only targets a non-full bank and reader only a full one, so set and clear never collide.
  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        full[gi] <= 1'b0;
      else if (wr_done && (wr_bank == 1'(gi)))
        full[gi] <= 1'b1;
      else if (rd_done && (rd_bank == 1'(gi)))
        full[gi] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_idx   <= 6'd0;
      dout_last  <= 1'b0;
    end else if (fetch) begin
      dout_valid <= 1'b1;
      dout       <= mem[{rd_bank, rd_cnt}];
      dout_idx   <= rd_cnt;
      dout_last  <= (rd_cnt == 6'd63);
    end else if (ena && dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_izigzag_buffer.sv
// Scoreboard bench for izigzag_buffer: the model assembles accepted zigzag beats into raster
// blocks and queues expected outputs; every handshaked output beat is popped and compared.
module tb_izigzag_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic        din_valid = 1'b0;
  logic [11:0] din = '0;
  logic        din_ready;
  logic        dout_valid;
  logic [11:0] dout;
  logic [5:0]  dout_idx;
  logic        dout_last;
  logic        dout_ready = 1'b0;
`ifdef IZZ_FLUSH_EN
  logic        flush = 1'b0;
`endif

  izigzag_buffer #(.COEFF_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
`ifdef IZZ_FLUSH_EN
    .flush      (flush),
`endif
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_idx   (dout_idx),
    .dout_last  (dout_last),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          zz_tb [64];
  logic [11:0] blk [64];
  logic [11:0] raster [64];
  int          mpos = 0;
  int          exp_q [$];
  logic        last_ready;
  int          phase = 0;
  int          last_phase = -1;
  int          run = 0;
  int          max_run = 0;
  int          acc_phase = 0;
  int          acc_edge = 0;
  int          first_dv_edge = -1;
  int          blocks_out = 0;
  logic [11:0] first_out [64];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Called once per cycle at the falling edge: observes the handshakes that the next rising edge completes.
  task automatic sample();
    int e;
    last_ready = din_ready;
    if (rst) begin
      mpos = 0;
      exp_q.delete();
      return;
    end
    if (phase != last_phase) begin
      last_phase    = phase;
      run           = 0;
      max_run       = 0;
      acc_phase     = 0;
      first_dv_edge = -1;
    end
`ifdef IZZ_FLUSH_EN
    if (ena && flush) mpos = 0;
`endif
    if (din_valid && din_ready) begin
      blk[mpos] = din;
      mpos++;
      acc_phase++;
      if (acc_phase == 64) acc_edge = cyc + 1;
      if (mpos == 64) begin
        for (int k = 0; k < 64; k++) raster[zz_tb[k]] = blk[k];
        for (int r = 0; r < 64; r++) exp_q.push_back(int'({r[5:0], raster[r]}));
        mpos = 0;
      end
    end
    if (dout_valid) begin
      run++;
      if (run > max_run) max_run = run;
      if (first_dv_edge < 0) first_dv_edge = cyc;
    end else begin
      run = 0;
    end
    if (dout_valid && dout_ready && ena) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("dout_idx", int'(dout_idx), int'(e[17:12]));
        check_eq("dout", int'(dout), int'(e[11:0]));
        check_eq("dout_last", int'(dout_last), int'(e[17:12] == 6'd63));
        if (phase == 1) first_out[dout_idx] = dout;
        if (dout_idx == 6'd63) begin
          blocks_out++;
          $display("block %0d emitted at cycle %0d (phase %0d)", blocks_out, cyc, phase);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [11:0] v);
    din_valid = 1'b1;
    din       = v;
    for (int w = 0; w < 2000; w++) begin
      tick();
      if (last_ready) break;
      if (w == 1999) check_eq("send_timeout", 0, 1);
    end
    din_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 3000 && exp_q.size() != 0; w++) tick();
    check_eq("drain_empty", exp_q.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    int idx;
    int acc;
    int edges;
    logic [5:0]  snap_idx;
    logic [11:0] snap_d;

    idx = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz_tb[idx] = 8 * r + (s - r);
          idx++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zz_tb[idx] = 8 * r + (s - r);
          idx++;
        end
      end
    end

    // Reset values
    #2;
    check_eq("rst_din_ready", int'(din_ready), 0);
    check_eq("rst_dout_valid", int'(dout_valid), 0);
    check_eq("rst_dout", int'(dout), 0);
    check_eq("rst_dout_idx", int'(dout_idx), 0);
    check_eq("rst_dout_last", int'(dout_last), 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("din_ready_after_rst", int'(din_ready), 1);

    // 1: counting block
    phase = 1;
    dout_ready = 1'b1;
    for (int k = 0; k < 64; k++) send(12'(k));
    drain();
    check_eq("raster0", int'(first_out[0]), 0);
    check_eq("raster1", int'(first_out[1]), 1);
    check_eq("raster2", int'(first_out[2]), 5);
    check_eq("raster8", int'(first_out[8]), 2);
    check_eq("raster63", int'(first_out[63]), 63);

    // 2: back-pressure fills both banks
    phase = 2;
    dout_ready = 1'b0;
    acc = 0;
    din_valid = 1'b1;
    for (int k = 0; k < 150; k++) begin
      din = 12'($urandom);
      tick();
      if (last_ready) acc++;
    end
    din_valid = 1'b0;
    check_eq("accepted_of_150", acc, 128);
    check_eq("din_ready_both_full", int'(din_ready), 0);
    dout_ready = 1'b1;
    for (edges = 1; edges <= 200; edges++) begin
      tick();
      if (din_ready) break;
    end
    check_eq("edges_to_din_ready", edges, 63);
    drain();

    // 3: continuous streaming of 4 blocks
    phase = 3;
    for (int k = 0; k < 256; k++) send(12'($urandom));
    drain();
    check_eq("valid_run", max_run, 256);
    check_eq("first_latency_edges", first_dv_edge - acc_edge + 1, 2);

    // 4: clock enable low mid-block while a block is being read
    phase = 4;
    for (int k = 0; k < 94; k++) send(12'($urandom));
    ena = 1'b0;
    din_valid = 1'b1;
    din = 12'hABC;
    snap_idx = dout_idx;
    snap_d = dout;
    check_eq("ena0_dout_valid_pre", int'(dout_valid), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("ena0_din_ready", int'(last_ready), 0);
      check_eq("ena0_dout_idx", int'(dout_idx), int'(snap_idx));
      check_eq("ena0_dout", int'(dout), int'(snap_d));
      check_eq("ena0_dout_valid", int'(dout_valid), 1);
    end
    ena = 1'b1;
    din_valid = 1'b0;
    for (int k = 0; k < 34; k++) send(12'($urandom));
    drain();

    // 5: reset with one bank full and a partial block
    phase = 5;
    dout_ready = 1'b0;
    for (int k = 0; k < 104; k++) send(12'($urandom));
    rst = 1'b1;
    #2;
    check_eq("midrst_din_ready", int'(din_ready), 0);
    check_eq("midrst_dout_valid", int'(dout_valid), 0);
    check_eq("midrst_dout", int'(dout), 0);
    check_eq("midrst_dout_idx", int'(dout_idx), 0);
    check_eq("midrst_dout_last", int'(dout_last), 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("midrst_din_ready_after", int'(din_ready), 1);
    dout_ready = 1'b1;
    for (int k = 0; k < 64; k++) send(12'($urandom));
    drain();

`ifdef IZZ_FLUSH_EN
    // 6: flush a partial block
    phase = 6;
    for (int k = 0; k < 20; k++) send(12'($urandom));
    flush = 1'b1;
    din_valid = 1'b1;
    din = 12'h555;
    tick();
    check_eq("flush_din_ready", int'(last_ready), 0);
    flush = 1'b0;
    din_valid = 1'b0;
    for (int k = 0; k < 64; k++) send(12'($urandom));
    drain();
`endif

    check_eq("queue_empty_end", exp_q.size(), 0);
    check_eq("dout_valid_idle", int'(dout_valid), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
